// File: rtl/spi_slave_if.sv
// SPI slave with oversampled pins, one-byte TX/RX holding registers and a cmd/wr/rd bus port.
// Define SPI_SLAVE_TX_REPEAT_EN to resend the last loaded byte on TX underrun instead of 0xFF.
module spi_slave_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       cmd,
    input  logic       wr,
    input  logic       rd,
    output logic [9:0] dout,
    output logic       ack,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic sck_prev_q, ss_prev_q;

    // ss synchronizer resets high so an idle bus is never mistaken for a selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, ss_s, mosi_s;
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       lsb_q, lsb_d;
    logic [7:0] tx_data_q, tx_data_d, tx_sh_q, tx_sh_d;
    logic       tx_full_q, tx_full_d, reload_q, reload_d;
    logic [6:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d, ovr_q, ovr_d;
    logic       miso_q, miso_d, oe_q, oe_d, ack_q, ack_d;
    logic [9:0] dout_q, dout_d;

    logic sck_rise, sck_fall, leading, trailing, sample, drive, ss_fall, ss_rise;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign leading  = mode_q[1] ? sck_fall : sck_rise;
    assign trailing = mode_q[1] ? sck_rise : sck_fall;
    assign sample   = mode_q[0] ? trailing : leading;
    assign drive    = mode_q[0] ? leading : trailing;
    assign ss_fall  = ss_prev_q & ~ss_s;
    assign ss_rise  = ~ss_prev_q & ss_s;

    logic [7:0] next_byte, next_ord, rx_byte;
`ifdef SPI_SLAVE_TX_REPEAT_EN
    logic [7:0] last_q;
    assign next_byte = tx_full_q ? tx_data_q : last_q;
`else
    assign next_byte = tx_full_q ? tx_data_q : 8'hFF;
`endif
    // Bytes are always shifted MSB-first internally; LSB-first just reverses at the edges.
    assign next_ord = lsb_q ? rev8(next_byte) : next_byte;
    assign rx_byte  = lsb_q ? rev8({rx_sh_q, mosi_s}) : {rx_sh_q, mosi_s};

    logic load, rx_done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        lsb_d      = lsb_q;
        tx_data_d  = tx_data_q;
        tx_full_d  = tx_full_q;
        tx_sh_d    = tx_sh_q;
        reload_d   = reload_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        ack_d      = cmd | wr | rd;
        dout_d     = '0;
        load       = 1'b0;
        rx_done    = 1'b0;

        if (cmd && ss_s) begin
            mode_d = din[1:0];
            lsb_d  = din[2];
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d  = ACTIVE;
                    cnt_d    = 3'd0;
                    oe_d     = 1'b1;
                    reload_d = 1'b0;
                    load     = 1'b1;
                    if (!mode_q[0]) begin
                        miso_d  = next_ord[7];
                        tx_sh_d = {next_ord[6:0], 1'b0};
                    end else begin
                        tx_sh_d = next_ord;
                    end
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d  = (cnt_q != 3'd0) ? ABORT : IDLE;
                    cnt_d    = 3'd0;
                    oe_d     = 1'b0;
                    miso_d   = 1'b0;
                    reload_d = 1'b0;
                end else if (sample) begin
                    rx_sh_d = {rx_sh_q[5:0], mosi_s};
                    if (cnt_q == 3'd7) begin
                        cnt_d    = 3'd0;
                        reload_d = 1'b1;
                        rx_done  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (drive) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                        miso_d   = next_ord[7];
                        tx_sh_d  = {next_ord[6:0], 1'b0};
                    end else begin
                        miso_d  = tx_sh_q[7];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A load in the same cycle as wr frees the holding register for the new byte.
        if (load) tx_full_d = 1'b0;
        if (wr && !(tx_full_q && !load)) begin
            tx_data_d = din;
            tx_full_d = 1'b1;
        end

        if (rd) begin
            dout_d     = {ovr_q, ~rx_valid_q, rx_valid_q ? rx_data_q : 8'h00};
            rx_valid_d = 1'b0;
            ovr_d      = 1'b0;
        end
        if (rx_done) begin
            if (!rx_valid_q || rd) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            mode_q     <= 2'd0;
            lsb_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_full_q  <= 1'b0;
            tx_sh_q    <= 8'h00;
            reload_q   <= 1'b0;
            rx_sh_q    <= 7'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            ack_q      <= 1'b0;
            dout_q     <= 10'h000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            lsb_q      <= lsb_d;
            tx_data_q  <= tx_data_d;
            tx_full_q  <= tx_full_d;
            tx_sh_q    <= tx_sh_d;
            reload_q   <= reload_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
        end
    end

`ifdef SPI_SLAVE_TX_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_q <= 8'hFF;
        else if (load) last_q <= next_byte;
    end
`endif

    assign dout        = dout_q;
    assign ack         = ack_q;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: bus responses and MISO bytes are queued and checked by monitors.
module tb_spi_slave_if;

    localparam int H      = 6;
    localparam int K_CMD  = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       cmd = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [9:0] dout;
    logic       ack;
    logic       spiSck = 1'b0, spiSs = 1'b1, spiMosi = 1'b0;
    logic       spiMiso, spiMisoOe;

    logic       cpol = 1'b0, cpha = 1'b0, lsbFirst = 1'b0;
    logic       reqLast = 1'b0;
    logic [9:0] expDout[$];
    logic [7:0] expMiso[$];
    logic [7:0] obsMiso[$];
    logic [9:0] doutExp;
    logic [7:0] misoObs;
    int         cmpCount = 0;
    int         errCount = 0;

    spi_slave_if #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .din(din), .cmd(cmd), .wr(wr), .rd(rd),
        .dout(dout), .ack(ack),
        .spi_sck(spiSck), .spi_ss(spiSs), .spi_mosi(spiMosi),
        .spi_miso(spiMiso), .spi_miso_oe(spiMisoOe)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) reqLast <= cmd | wr | rd;

    // Bus monitor: every ack pops one expected dout; ack must follow a request by one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack || reqLast) checkOutput("ack_timing", ack, reqLast);
            if (ack) begin
                if (expDout.size() == 0) checkOutput("ack_unexpected", ack, 1'b0);
                else begin
                    doutExp = expDout.pop_front();
                    checkOutput("dout", dout, doutExp);
                end
            end
        end
    end

    // MISO monitor: compares each byte the master model captured against the expected byte.
    always @(negedge clk) begin
        while (obsMiso.size() > 0) begin
            misoObs = obsMiso.pop_front();
            if (expMiso.size() == 0) begin
                cmpCount++;
                errCount++;
                $display("[TB] FAIL miso_unexpected: got 0x%0h, expected none", misoObs);
            end else begin
                checkOutput("miso_byte", misoObs, expMiso.pop_front());
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int kind, input logic [7:0] d, input logic [9:0] exp);
        expDout.push_back(exp);
        din = d;
        cmd = (kind == K_CMD);
        wr  = (kind == K_WR);
        rd  = (kind == K_RD);
        @(posedge clk);
        #1;
        cmd = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic setMode(input logic pol, input logic pha, input logic lsb);
        applyStimulus(K_CMD, {5'b0, lsb, pol, pha}, 10'h000);
        cpol = pol;
        cpha = pha;
        lsbFirst = lsb;
        spiSck = pol;
        waitCycles(4);
    endtask

    task automatic selectLow();
        spiSs = 1'b0;
        waitCycles(8);
    endtask

    task automatic deselect();
        waitCycles(8);
        spiSs = 1'b1;
        waitCycles(6);
    endtask

    task automatic spiBits(input logic [7:0] tx, input int nbits, input logic [7:0] expM);
        logic [7:0] rxb;
        int idx;
        rxb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbFirst ? i : 7 - i;
            if (!cpha) begin
                spiMosi = tx[idx];
                waitCycles(H);
                spiSck = ~spiSck;
                rxb[idx] = spiMiso;
                waitCycles(H);
                spiSck = ~spiSck;
            end else begin
                spiSck = ~spiSck;
                spiMosi = tx[idx];
                waitCycles(H);
                spiSck = ~spiSck;
                rxb[idx] = spiMiso;
                waitCycles(H);
            end
        end
        if (nbits == 8) begin
            expMiso.push_back(expM);
            obsMiso.push_back(rxb);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2 rst = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(2);
        checkOutput("reset_dout", dout, 10'h000);
        checkOutput("reset_ack", ack, 1'b0);
        checkOutput("reset_miso", spiMiso, 1'b0);
        checkOutput("reset_miso_oe", spiMisoOe, 1'b0);

        $display("[TB] mode 0 MSB first, A5 out / 3C in");
        applyStimulus(K_WR, 8'hA5, 10'h000);
        selectLow();
        checkOutput("oe_selected", spiMisoOe, 1'b1);
        checkOutput("cpha0_first_bit", spiMiso, 1'b1);
        spiBits(8'h3C, 8, 8'hA5);
        deselect();
        checkOutput("oe_deselected", spiMisoOe, 1'b0);
        applyStimulus(K_RD, 8'h00, 10'h03C);
        applyStimulus(K_RD, 8'h00, 10'h100);

        $display("[TB] mode 3 LSB first, 01 out / 80 in");
        setMode(1'b1, 1'b1, 1'b1);
        applyStimulus(K_WR, 8'h01, 10'h000);
        selectLow();
        spiBits(8'h80, 8, 8'h01);
        deselect();
        applyStimulus(K_RD, 8'h00, 10'h080);

        $display("[TB] two bytes, one TX write, overrun");
        setMode(1'b0, 1'b0, 1'b0);
        applyStimulus(K_WR, 8'h55, 10'h000);
        selectLow();
        spiBits(8'h11, 8, 8'h55);
`ifdef SPI_SLAVE_TX_REPEAT_EN
        spiBits(8'h22, 8, 8'h55);
`else
        spiBits(8'h22, 8, 8'hFF);
`endif
        deselect();
        applyStimulus(K_RD, 8'h00, 10'h211);
        applyStimulus(K_RD, 8'h00, 10'h100);

        $display("[TB] abort after four bits");
        selectLow();
        spiBits(8'hF0, 4, 8'h00);
        deselect();
        checkOutput("abort_oe", spiMisoOe, 1'b0);
        checkOutput("abort_miso", spiMiso, 1'b0);
        applyStimulus(K_RD, 8'h00, 10'h100);
        applyStimulus(K_WR, 8'hC3, 10'h000);
        selectLow();
        spiBits(8'h5A, 8, 8'hC3);
        deselect();
        applyStimulus(K_RD, 8'h00, 10'h05A);

        $display("[TB] cmd while selected is ignored");
        applyStimulus(K_WR, 8'h81, 10'h000);
        selectLow();
        applyStimulus(K_CMD, 8'h03, 10'h000);
        spiBits(8'h7E, 8, 8'h81);
        deselect();
        applyStimulus(K_RD, 8'h00, 10'h07E);
        setMode(1'b1, 1'b1, 1'b0);
        applyStimulus(K_WR, 8'h42, 10'h000);
        selectLow();
        spiBits(8'hE7, 8, 8'h42);
        deselect();
        applyStimulus(K_RD, 8'h00, 10'h0E7);

        $display("[TB] asynchronous reset while selected");
        selectLow();
        checkOutput("pre_reset_oe", spiMisoOe, 1'b1);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_oe", spiMisoOe, 1'b0);
        spiSs = 1'b1;
        spiSck = 1'b0;
        cpol = 1'b0;
        cpha = 1'b0;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(6);
        checkOutput("post_reset_oe", spiMisoOe, 1'b0);

        waitCycles(5);
        checkOutput("dout_queue_drained", expDout.size(), 0);
        checkOutput("miso_queue_drained", expMiso.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
